// File: rtl/down_timer.sv
// down_timer: loadable down-counter / timeout engine.
// Counts from a loaded value to zero, pulses tc for one cycle, then either
// stops in DONE (one-shot) or reloads and keeps running (auto-reload).
// Optional build macro DOWN_TIMER_PRESCALE_EN adds a `prescale` port and a
// PRESCALE_W-bit prescaler producing one tick every prescale+1 cycles in RUN.
module down_timer #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  auto_reload,
`ifdef DOWN_TIMER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      q,
  output logic                  tc,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

`ifdef DOWN_TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] psc_q, psc_d;

  assign tick = (psc_q == prescale);

  // Prescaler: free-runs only while counting; any load, stop or effective
  // start restarts the divide so the first tick lands prescale+1 edges later.
  always_comb begin
    psc_d = '0;
    if (!load && !stop && state_q == ST_RUN && !tick)
      psc_d = psc_q + 1'b1;
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) psc_q <= '0;
    else     psc_q <= psc_d;
  end
`else
  assign tick = 1'b1;
`endif

  // Next-state / datapath: priority load > stop > start > tick.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      q_d      = load_val;
      reload_d = load_val;
      state_d  = ST_IDLE;
    end else if (stop && state_q == ST_RUN) begin
      state_d = ST_IDLE;
    end else if (start && state_q != ST_RUN) begin
      // q is left alone on the start edge; the first decrement is one tick later.
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && tick) begin
      if (q_q != '0) begin
        q_d = q_q - 1'b1;
      end else begin
        // Terminal event: auto_reload is only looked at here.
        tc_d = 1'b1;
        if (auto_reload) q_d = reload_q;
        else             state_d = ST_DONE;
      end
    end
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign q    = q_q;
  assign tc   = tc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed stimulus; each driven cycle pushes the expected
// post-edge {q,tc,busy,done} into a queue, and a monitor pops and compares
// after every clock edge.
module tb_down_timer;

  logic       clk = 1'b0;
  logic       rst, load, start, stop, auto_reload;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc, busy, done;
`ifdef DOWN_TIMER_PRESCALE_EN
  logic [3:0] prescale = 4'd0;
`endif

  down_timer #(.WIDTH(4), .PRESCALE_W(4)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .auto_reload(auto_reload),
`ifdef DOWN_TIMER_PRESCALE_EN
    .prescale(prescale),
`endif
    .q(q), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] exp;
    int         id;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad   = 0;
  int  step_id = 0;

  function automatic logic [6:0] E(input logic [3:0] eq, input logic etc, eb, ed);
    return {eq, etc, eb, ed};
  endfunction

  // Drive one cycle of inputs and record what the outputs must be after the edge.
  task automatic step(input logic i_rst, i_load, input logic [3:0] lv,
                      input logic i_start, i_stop, i_ar, input logic [6:0] ex);
    sb_t s;
    @(negedge clk);
    rst = i_rst; load = i_load; load_val = lv;
    start = i_start; stop = i_stop; auto_reload = i_ar;
    s.exp = ex; s.id = step_id;
    sb_q.push_back(s);
    step_id++;
  endtask

  // Monitor: outputs are registered, so check just after each rising edge.
  initial begin
    sb_t s;
    logic [6:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        s = sb_q.pop_front();
        got = {q, tc, busy, done};
        total++;
        if (got !== s.exp) begin
          bad++;
          $display("FAIL step%0d {q,tc,busy,done}: got q=%0d tc=%b busy=%b done=%b, want q=%0d tc=%b busy=%b done=%b",
                   s.id, got[6:3], got[2], got[1], got[0],
                   s.exp[6:3], s.exp[2], s.exp[1], s.exp[0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0; auto_reload = 1'b0;

    // Reset state
    step(1,0,0,0,0,0, E(0,0,0,0));
    step(1,0,0,0,0,0, E(0,0,0,0));

    // One-shot from 5: q 5..0, tc at k+6, then DONE holding 0
    step(0,1,5,0,0,0, E(5,0,0,0));
    step(0,0,0,1,0,0, E(5,0,1,0));
    for (int i = 4; i >= 0; i--) step(0,0,0,0,0,0, E(i[3:0],0,1,0));
    step(0,0,0,0,0,0, E(0,1,0,1));
    step(0,0,0,0,0,0, E(0,0,0,1));
    step(0,0,0,0,0,0, E(0,0,0,1));

    // Auto-reload from 3: period 4, then drop auto_reload before the next tc
    step(0,1,3,0,0,1, E(3,0,0,0));
    step(0,0,0,1,0,1, E(3,0,1,0));
    for (int r = 0; r < 2; r++) begin
      for (int i = 2; i >= 0; i--) step(0,0,0,0,0,1, E(i[3:0],0,1,0));
      step(0,0,0,0,0,1, E(3,1,1,0));
    end
    step(0,0,0,0,0,1, E(2,0,1,0));
    step(0,0,0,0,0,0, E(1,0,1,0));
    step(0,0,0,0,0,0, E(0,0,1,0));
    step(0,0,0,0,0,0, E(0,1,0,1));
    step(0,0,0,0,0,0, E(0,0,0,1));

    // Stop at 6, hold, resume with no skipped/repeated value
    step(0,1,9,0,0,0, E(9,0,0,0));
    step(0,0,0,1,0,0, E(9,0,1,0));
    for (int i = 8; i >= 6; i--) step(0,0,0,0,0,0, E(i[3:0],0,1,0));
    step(0,0,0,0,1,0, E(6,0,0,0));
    for (int i = 0; i < 3; i++) step(0,0,0,0,0,0, E(6,0,0,0));
    step(0,0,0,1,0,0, E(6,0,1,0));
    step(0,0,0,0,0,0, E(5,0,1,0));
    step(0,0,0,0,0,0, E(4,0,1,0));
    // Load during RUN aborts the count
    step(0,1,2,0,0,0, E(2,0,0,0));
    step(0,0,0,0,0,0, E(2,0,0,0));
    step(0,0,0,0,0,0, E(2,0,0,0));

    // load+start same edge: load wins
    step(0,1,7,1,0,0, E(7,0,0,0));
    step(0,0,0,0,0,0, E(7,0,0,0));
    // stop+start in RUN: IDLE
    step(0,0,0,1,0,0, E(7,0,1,0));
    step(0,0,0,0,0,0, E(6,0,1,0));
    step(0,0,0,1,1,0, E(6,0,0,0));
    step(0,0,0,0,0,0, E(6,0,0,0));
    // start during RUN ignored
    step(0,0,0,1,0,0, E(6,0,1,0));
    step(0,0,0,1,0,0, E(5,0,1,0));
    step(0,0,0,1,0,0, E(4,0,1,0));
    step(0,0,0,0,0,0, E(3,0,1,0));

    // Reset mid-count, no tc afterwards
    step(1,0,0,0,0,0, E(0,0,0,0));
    step(1,0,0,0,0,0, E(0,0,0,0));
    for (int i = 0; i < 4; i++) step(0,0,0,0,0,0, E(0,0,0,0));

    // start with q==0: tc after first tick
    step(0,0,0,1,0,0, E(0,0,1,0));
    step(0,0,0,0,0,0, E(0,1,0,1));
    // Reload value 0 with auto_reload: tc every tick
    step(0,1,0,0,0,1, E(0,0,0,0));
    step(0,0,0,1,0,1, E(0,0,1,0));
    for (int i = 0; i < 3; i++) step(0,0,0,0,0,1, E(0,1,1,0));
    step(0,0,0,0,0,0, E(0,1,0,1));
    step(0,0,0,0,0,0, E(0,0,0,1));

    // Full-scale one-shot: 15 down to 0, never wraps
    step(0,1,15,0,0,0, E(15,0,0,0));
    step(0,0,0,1,0,0, E(15,0,1,0));
    for (int i = 14; i >= 0; i--) step(0,0,0,0,0,0, E(i[3:0],0,1,0));
    step(0,0,0,0,0,0, E(0,1,0,1));
    step(0,0,0,0,0,0, E(0,0,0,1));

`ifdef DOWN_TIMER_PRESCALE_EN
    // prescale=2, load 2: decrement every 3 cycles, tc 9 cycles after start
    prescale = 4'd2;
    step(0,1,2,0,0,0, E(2,0,0,0));
    step(0,0,0,1,0,0, E(2,0,1,0));
    step(0,0,0,0,0,0, E(2,0,1,0));
    step(0,0,0,0,0,0, E(2,0,1,0));
    step(0,0,0,0,0,0, E(1,0,1,0));
    step(0,0,0,0,0,0, E(1,0,1,0));
    step(0,0,0,0,0,0, E(1,0,1,0));
    step(0,0,0,0,0,0, E(0,0,1,0));
    step(0,0,0,0,0,0, E(0,0,1,0));
    step(0,0,0,0,0,0, E(0,0,1,0));
    step(0,0,0,0,0,0, E(0,1,0,1));
    step(0,0,0,0,0,0, E(0,0,0,1));
`endif

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
